// File: rtl/disp_seq_pkg.sv
// rtl/disp_seq_pkg.sv - shared types and constants for the display scan sequencer
package disp_seq_pkg;

  typedef enum logic [1:0] {
    SHOW   = 2'd0,
    FETCH  = 2'd1,
    DRAIN  = 2'd2,
    COMMIT = 2'd3
  } seq_state_t;

  localparam int NUM_DIGITS = 4;
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [6:0] BLANK_DEFAULT = 7'h7F;

endpackage

// File: rtl/display_scan_sequencer_digit_scanner.sv
// rtl/display_scan_sequencer_digit_scanner.sv - refresh counter, anode decode and segment mux
module digit_scanner
  import disp_seq_pkg::*;
#(
  parameter int DATA_W = 7,
  parameter logic [DATA_W-1:0] BLANK = BLANK_DEFAULT
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         refresh_tick,
  input  logic [NUM_DIGITS*DATA_W-1:0] shadow,
  output logic [NUM_DIGITS-1:0]        an,
  output logic [DATA_W-1:0]            seg
);

  logic [IDX_W-1:0] idx;

  // an and seg are loaded together so a digit never shows its neighbour's pattern
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx <= '0;
      an  <= '1;
      seg <= BLANK;
    end else if (refresh_tick) begin
      idx <= idx + 1'b1;
      an  <= ~(NUM_DIGITS'(1) << idx);
      seg <= shadow[idx*DATA_W +: DATA_W];
    end
  end

endmodule

// File: rtl/display_scan_sequencer.sv
// rtl/display_scan_sequencer.sv - scroll position, ROM fetch FSM and shadow buffer for the 4-digit display
module display_scan_sequencer
  import disp_seq_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 7,
  parameter int MSG_LEN = 16,
  parameter logic [DATA_W-1:0] BLANK = BLANK_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  step_tick,
  input  logic                  refresh_tick,
  input  logic                  btn_pause,
  input  logic                  btn_step,
  input  logic [DATA_W-1:0]     rom_data,
  output logic                  rom_rd,
  output logic [ADDR_W-1:0]     rom_addr,
  output logic [ADDR_W-1:0]     base_addr,
  output logic                  paused,
  output logic [NUM_DIGITS-1:0] an,
  output logic [DATA_W-1:0]     seg
);

  seq_state_t state, next_state;
  logic [1:0] k, k_next;
  logic [ADDR_W-1:0] base_next, rom_addr_d;
  logic pending, pending_next, init_done, advance, rom_rd_d, cap_en;
  logic [1:0] cap_idx;
  logic [NUM_DIGITS-1:0][DATA_W-1:0] fetch_buf, shadow;

  function automatic logic [ADDR_W-1:0] wrap_add(input logic [ADDR_W-1:0] a, input logic [1:0] b);
    return ADDR_W'((32'(a) + 32'(b)) % 32'(MSG_LEN));
  endfunction

  // a simultaneous pause toggle swallows the single-step press
  assign advance = paused ? (btn_step & ~btn_pause) : step_tick;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= SHOW;
      k         <= '0;
      base_addr <= '0;
      pending   <= 1'b0;
      init_done <= 1'b0;
      paused    <= 1'b0;
    end else begin
      state     <= next_state;
      k         <= k_next;
      base_addr <= base_next;
      pending   <= pending_next;
      init_done <= 1'b1;
      paused    <= paused ^ btn_pause;
    end
  end

  always_comb begin
    next_state   = state;
    base_next    = base_addr;
    pending_next = pending;
    k_next       = 2'd0;
    case (state)
      SHOW: begin
        if (advance) begin
          base_next  = wrap_add(base_addr, 2'd1);
          next_state = FETCH;
        end else if (!init_done) begin
          next_state = FETCH;
        end
      end
      FETCH: begin
        if (advance) pending_next = 1'b1;
        if (k == 2'd3) next_state = DRAIN;
        else k_next = k + 2'd1;
      end
      DRAIN: begin
        if (advance) pending_next = 1'b1;
        next_state = COMMIT;
      end
      COMMIT: begin
        if (pending || advance) begin
          base_next    = wrap_add(base_addr, 2'd1);
          pending_next = 1'b0;
          next_state   = FETCH;
        end else begin
          next_state = SHOW;
        end
      end
      default: next_state = SHOW;
    endcase
  end

  // ROM strobe/address are registered, so they are derived from the next state
  always_comb begin
    rom_rd_d   = (next_state == FETCH);
    rom_addr_d = rom_rd_d ? wrap_add(base_next, k_next) : rom_addr;
    cap_en     = ((state == FETCH) && (k != 2'd0)) || (state == DRAIN);
    cap_idx    = (state == DRAIN) ? 2'd3 : k - 2'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rom_rd    <= 1'b0;
      rom_addr  <= '0;
      fetch_buf <= {NUM_DIGITS{BLANK}};
      shadow    <= {NUM_DIGITS{BLANK}};
    end else begin
      rom_rd   <= rom_rd_d;
      rom_addr <= rom_addr_d;
      if (cap_en) fetch_buf[cap_idx] <= rom_data;
      if (state == COMMIT) shadow <= fetch_buf;
    end
  end

  digit_scanner #(
    .DATA_W(DATA_W),
    .BLANK (BLANK)
  ) u_scanner (
    .clk         (clk),
    .reset       (reset),
    .refresh_tick(refresh_tick),
    .shadow      (shadow),
    .an          (an),
    .seg         (seg)
  );

endmodule

// File: tb/tb_display_scan_sequencer.sv
// tb/tb_display_scan_sequencer.sv - directed self-checking bench for display_scan_sequencer
module tb_display_scan_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       step_tick = 1'b0;
  logic       refresh_tick = 1'b0;
  logic       btn_pause = 1'b0;
  logic       btn_step = 1'b0;
  logic [6:0] rom_data = 7'd0;
  logic       rom_rd;
  logic [3:0] rom_addr;
  logic [3:0] base_addr;
  logic       paused;
  logic [3:0] an;
  logic [6:0] seg;

  logic [6:0] rom_mem [16];
  logic [3:0] log_q [$];
  int n_cmp = 0;
  int n_err = 0;

  display_scan_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .step_tick   (step_tick),
    .refresh_tick(refresh_tick),
    .btn_pause   (btn_pause),
    .btn_step    (btn_step),
    .rom_data    (rom_data),
    .rom_rd      (rom_rd),
    .rom_addr    (rom_addr),
    .base_addr   (base_addr),
    .paused      (paused),
    .an          (an),
    .seg         (seg)
  );

  always #5 clk = ~clk;

  initial for (int i = 0; i < 16; i++) rom_mem[i] = 7'(i);

  always @(posedge clk) if (rom_rd) rom_data <= rom_mem[rom_addr];
  always @(negedge clk) if (!reset && rom_rd) log_q.push_back(rom_addr);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_step();
    step_tick = 1'b1;
    tick(1);
    step_tick = 1'b0;
  endtask

  task automatic advance_and_wait();
    log_q.delete();
    pulse_step();
    tick(8);
  endtask

  logic [3:0] exp_an [5];
  logic [6:0] exp_seg [5];

  initial begin
    exp_an  = '{4'he, 4'hd, 4'hb, 4'h7, 4'he};
    exp_seg = '{7'd0, 7'd1, 7'd2, 7'd3, 7'd0};

    tick(3);
    chk("rst_base", base_addr, 4'd0);
    chk("rst_paused", paused, 1'b0);
    chk("rst_rom_rd", rom_rd, 1'b0);
    chk("rst_rom_addr", rom_addr, 4'd0);
    chk("rst_an", an, 4'hf);
    chk("rst_seg", seg, 7'h7f);

    reset = 1'b0;
    tick(10);
    chk("init_rd_count", log_q.size(), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("init_addr%0d", i), log_q[i], 4'(i));
    chk("init_base", base_addr, 4'd0);

    for (int i = 0; i < 5; i++) begin
      refresh_tick = 1'b1;
      tick(1);
      refresh_tick = 1'b0;
      chk($sformatf("scan_an%0d", i), an, exp_an[i]);
      chk($sformatf("scan_seg%0d", i), seg, exp_seg[i]);
    end

    for (int i = 0; i < 14; i++) advance_and_wait();
    chk("base14", base_addr, 4'd14);
    advance_and_wait();
    chk("base15", base_addr, 4'd15);
    chk("b14_rd_count", log_q.size(), 4);
    chk("b14_addr0", log_q[0], 4'd15);
    chk("b14_addr1", log_q[1], 4'd0);
    chk("b14_addr3", log_q[3], 4'd2);
    advance_and_wait();
    chk("wrap_base", base_addr, 4'd0);
    chk("wrap_rd_count", log_q.size(), 4);
    chk("wrap_addr0", log_q[0], 4'd0);
    chk("wrap_addr3", log_q[3], 4'd3);

    btn_pause = 1'b1;
    tick(1);
    btn_pause = 1'b0;
    chk("pause_on", paused, 1'b1);
    log_q.delete();
    repeat (3) begin
      pulse_step();
      tick(2);
    end
    tick(4);
    chk("pause_base", base_addr, 4'd0);
    chk("pause_no_rd", log_q.size(), 0);

    btn_step = 1'b1;
    tick(1);
    btn_step = 1'b0;
    tick(8);
    chk("single_base", base_addr, 4'd1);
    chk("single_rd_count", log_q.size(), 4);
    chk("single_addr0", log_q[0], 4'd1);

    log_q.delete();
    btn_pause = 1'b1;
    btn_step = 1'b1;
    tick(1);
    btn_pause = 1'b0;
    btn_step = 1'b0;
    tick(8);
    chk("both_paused", paused, 1'b0);
    chk("both_base", base_addr, 4'd1);
    chk("both_no_rd", log_q.size(), 0);

    btn_step = 1'b1;
    tick(1);
    btn_step = 1'b0;
    tick(8);
    chk("run_btn_step_base", base_addr, 4'd1);

    log_q.delete();
    pulse_step();
    tick(2);
    pulse_step();
    tick(1);
    pulse_step();
    tick(20);
    chk("pend_base", base_addr, 4'd3);
    chk("pend_rd_count", log_q.size(), 8);
    chk("pend_addr3", log_q[3], 4'd5);
    chk("pend_addr4", log_q[4], 4'd3);
    chk("pend_addr7", log_q[7], 4'd6);

    pulse_step();
    tick(1);
    chk("mid_rom_rd", rom_rd, 1'b1);
    #3;
    reset = 1'b1;
    #1;
    chk("mid_rst_rom_rd", rom_rd, 1'b0);
    chk("mid_rst_an", an, 4'hf);
    chk("mid_rst_seg", seg, 7'h7f);
    chk("mid_rst_base", base_addr, 4'd0);
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
